// File: rtl/sha256_msg_padder_if.sv
// Bus bundle for sha256_msg_padder: message-memory read port plus the padded-block
// valid/ready stream toward the compression core.
interface sha256_msg_padder_if;
  logic         mem_clk;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [7:0]   blk_index;

  modport master (
    output mem_clk, mem_we, mem_addr,
    input  mem_read_data,
    output blk_valid, blk_data, blk_last, blk_index,
    input  blk_ready
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr,
    output mem_read_data,
    input  blk_valid, blk_data, blk_last, blk_index,
    output blk_ready
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from memory and offers padded 512-bit blocks.
// Optional macro SHA256_PADDER_BSWAP_EN byte-reverses every word read from memory.
//
// state | meaning
// IDLE  | waiting for start; block index and slot held at 0
// FILL  | issuing slots 0..15, each word lands in the buffer one edge after issue
// OFFER | complete block presented on blk_data until blk_ready
// FIN   | one-cycle done pulse after the last block is accepted
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                message_addr,
  sha256_msg_padder_if.master        bus,
  output logic                       busy,
  output logic                       done
);

  localparam int          NB       = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] N_G      = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_LO_G = 16'(16 * NB - 1);
  localparam logic [31:0] BIT_LEN  = 32'(32 * NUM_OF_WORDS);
  localparam logic [7:0]  LAST_BLK = 8'(NB - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  slot_q, slot_d;
  logic [7:0]  blk_index_q, blk_index_d;
  logic [15:0] base_q, base_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_mem_q, pend_mem_d;
  logic [3:0]  pend_slot_q, pend_slot_d;
  logic [31:0] pend_pad_q, pend_pad_d;
  logic [31:0] wbuf_q [0:15];
  logic [31:0] wbuf_d [0:15];

  logic [15:0] g;
  logic        is_mem;
  logic [31:0] pad_word;
  logic [31:0] cap_word;

  function automatic logic [31:0] mem_word(input logic [31:0] w);
`ifdef SHA256_PADDER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // 16*blk_index + slot is just the concatenation of the two counters
  assign g        = {4'b0000, blk_index_q, slot_q[3:0]};
  assign is_mem   = (g < N_G);
  assign pad_word = (g == N_G)      ? 32'h8000_0000 :
                    (g == LEN_LO_G) ? BIT_LEN       : 32'h0000_0000;
  assign cap_word = pend_mem_q ? mem_word(bus.mem_read_data) : pend_pad_q;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    blk_index_d = blk_index_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    pend_vld_d  = 1'b0;
    pend_mem_d  = pend_mem_q;
    pend_slot_d = pend_slot_q;
    pend_pad_d  = pend_pad_q;
    wbuf_d      = wbuf_q;

    if (pend_vld_q) wbuf_d[pend_slot_q] = cap_word;

    case (state_q)
      S_IDLE: begin
        slot_d      = 5'd0;
        blk_index_d = 8'd0;
        if (start) begin
          state_d = S_FILL;
          base_d  = message_addr;
        end
      end
      S_FILL: begin
        if (!slot_q[4]) begin
          pend_vld_d  = 1'b1;
          pend_slot_d = slot_q[3:0];
          pend_mem_d  = is_mem;
          pend_pad_d  = pad_word;
          if (is_mem) mem_addr_d = base_q + g;
          slot_d = slot_q + 5'd1;
        end else begin
          // slot 15 is being captured on this edge
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (bus.blk_ready) begin
          if (blk_index_q == LAST_BLK) begin
            state_d = S_FIN;
          end else begin
            blk_index_d = blk_index_q + 8'd1;
            slot_d      = 5'd0;
            state_d     = S_FILL;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slot_q      <= 5'd0;
      blk_index_q <= 8'd0;
      base_q      <= 16'd0;
      mem_addr_q  <= 16'd0;
      pend_vld_q  <= 1'b0;
      pend_mem_q  <= 1'b0;
      pend_slot_q <= 4'd0;
      pend_pad_q  <= 32'd0;
      for (int i = 0; i < 16; i++) wbuf_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      blk_index_q <= blk_index_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      pend_vld_q  <= pend_vld_d;
      pend_mem_q  <= pend_mem_d;
      pend_slot_q <= pend_slot_d;
      pend_pad_q  <= pend_pad_d;
      wbuf_q      <= wbuf_d;
    end
  end

  assign bus.mem_clk   = clk;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.blk_valid = (state_q == S_OFFER);
  assign bus.blk_last  = (state_q == S_OFFER) && (blk_index_q == LAST_BLK);
  assign bus.blk_index = blk_index_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);

  always_comb begin
    bus.blk_data = '0;
    for (int s = 0; s < 16; s++) bus.blk_data[511 - 32*s -: 32] = wbuf_q[s];
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: three instances (N=20, 13, 14) share one memory image;
// expected blocks are built from the memory image and queued at start, popped on each offer.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        ready;
  logic [1:0]  sel;
  logic [15:0] message_addr;
  logic [31:0] mem [0:65535];

  int tests_run    = 0;
  int tests_failed = 0;

  sha256_msg_padder_if b20 ();
  sha256_msg_padder_if b13 ();
  sha256_msg_padder_if b14 ();

  logic busy20, busy13, busy14, done20, done13, done14;

  assign b20.mem_read_data = mem[b20.mem_addr];
  assign b13.mem_read_data = mem[b13.mem_addr];
  assign b14.mem_read_data = mem[b14.mem_addr];
  assign b20.blk_ready = ready && (sel == 2'd0);
  assign b13.blk_ready = ready && (sel == 2'd1);
  assign b14.blk_ready = ready && (sel == 2'd2);

  sha256_msg_padder #(.NUM_OF_WORDS(20)) dut20 (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd0)), .message_addr(message_addr),
    .bus(b20.master), .busy(busy20), .done(done20));
  sha256_msg_padder #(.NUM_OF_WORDS(13)) dut13 (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd1)), .message_addr(message_addr),
    .bus(b13.master), .busy(busy13), .done(done13));
  sha256_msg_padder #(.NUM_OF_WORDS(14)) dut14 (
    .clk(clk), .reset(reset), .start(start && (sel == 2'd2)), .message_addr(message_addr),
    .bus(b14.master), .busy(busy14), .done(done14));

  logic         v_valid, v_last, v_busy, v_done, v_we, v_mclk;
  logic [7:0]   v_idx;
  logic [15:0]  v_addr;
  logic [511:0] v_data;

  always_comb begin
    v_valid = b20.blk_valid; v_last = b20.blk_last; v_idx = b20.blk_index; v_data = b20.blk_data;
    v_addr = b20.mem_addr; v_we = b20.mem_we; v_mclk = b20.mem_clk; v_busy = busy20; v_done = done20;
    case (sel)
      2'd1: begin
        v_valid = b13.blk_valid; v_last = b13.blk_last; v_idx = b13.blk_index; v_data = b13.blk_data;
        v_addr = b13.mem_addr; v_we = b13.mem_we; v_mclk = b13.mem_clk; v_busy = busy13; v_done = done13;
      end
      2'd2: begin
        v_valid = b14.blk_valid; v_last = b14.blk_last; v_idx = b14.blk_index; v_data = b14.blk_data;
        v_addr = b14.mem_addr; v_we = b14.mem_we; v_mclk = b14.mem_clk; v_busy = busy14; v_done = done14;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [7:0]   idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic logic [511:0] exp_block(input int n, input logic [15:0] base, input int b);
    logic [511:0] r;
    logic [31:0]  w;
    int           nb;
    int           gi;
    nb = (n + 18) / 16;
    r  = '0;
    for (int s = 0; s < 16; s++) begin
      gi = 16 * b + s;
      if (gi < n) begin
        w = mem[base + 16'(gi)];
`ifdef SHA256_PADDER_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      end else if (gi == n) w = 32'h8000_0000;
      else if (gi == 16 * nb - 1) w = 32'(32 * n);
      else w = 32'h0;
      r[511 - 32*s -: 32] = w;
    end
    return r;
  endfunction

  task automatic load_msg(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) mem[base + 16'(i)] = 32'(i + 1);
  endtask

  task automatic push_msg(input int n, input logic [15:0] base);
    exp_t x;
    int   nb;
    nb = (n + 18) / 16;
    for (int b = 0; b < nb; b++) begin
      x.data = exp_block(n, base, b);
      x.last = (b == nb - 1);
      x.idx  = 8'(b);
      sb.push_back(x);
    end
  endtask

  task automatic pop_exp();
    if (sb.size() != 0) e = sb.pop_front();
    else begin e.data = '0; e.last = 1'b0; e.idx = 8'd0; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts posedges crossed until blk_valid is seen at a negedge
  task automatic wait_valid(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (v_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ready = 1'b0; sel = 2'd0; message_addr = 16'h0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({v_valid, v_last, v_idx, v_busy, v_done, v_addr, v_we} !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got valid=%b last=%b idx=%0d busy=%b done=%b addr=%h we=%b required all 0",
               v_valid, v_last, v_idx, v_busy, v_done, v_addr, v_we);
    end
    tests_run++;
    if (v_data !== 512'd0) begin tests_failed++; $display("FAIL reset_data got %h required 0", v_data); end
    tests_run++;
    if (v_mclk !== clk) begin tests_failed++; $display("FAIL mem_clk got %b required %b", v_mclk, clk); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n20(input logic [15:0] base);
    bit ok; int cyc;
    sel = 2'd0; ready = 1'b1; message_addr = base;
    load_msg(20, base);
    push_msg(20, base);
    pulse_start();
    for (int b = 0; b < 2; b++) begin
      wait_valid(40, ok, cyc);
      tests_run++;
      if (!ok || cyc != (b == 0 ? 17 : 18)) begin
        tests_failed++; $display("FAIL n20_latency base=%h blk%0d got %0d edges ok=%b required %0d", base, b, cyc, ok, (b == 0 ? 17 : 18));
      end
      pop_exp();
      tests_run++;
      if (v_data !== e.data) begin tests_failed++; $display("FAIL n20_data base=%h blk%0d got %h required %h", base, b, v_data, e.data); end
      tests_run++;
      if ({v_last, v_idx} !== {e.last, e.idx}) begin
        tests_failed++; $display("FAIL n20_last_idx blk%0d got last=%b idx=%0d required last=%b idx=%0d", b, v_last, v_idx, e.last, e.idx);
      end
      if (b == 0) begin
        tests_run++;
        if (v_data[511:480] !== 32'd1) begin tests_failed++; $display("FAIL n20_word0 got %h required 00000001", v_data[511:480]); end
      end else begin
        tests_run++;
        if ({v_data[383:352], v_data[63:0]} !== {32'h8000_0000, 32'h0, 32'h0000_0280}) begin
          tests_failed++; $display("FAIL n20_pad got w4=%h w14..15=%h required 80000000 / 0000000000000280", v_data[383:352], v_data[63:0]);
        end
      end
    end
    @(negedge clk);
    tests_run++;
    if ({v_done, v_busy} !== 2'b11) begin tests_failed++; $display("FAIL n20_done_pulse got done=%b busy=%b required 1 1", v_done, v_busy); end
    @(negedge clk);
    tests_run++;
    if ({v_done, v_busy} !== 2'b00) begin tests_failed++; $display("FAIL n20_done_end got done=%b busy=%b required 0 0", v_done, v_busy); end
  endtask

  task automatic test_n13();
    bit ok; int cyc;
    sel = 2'd1; ready = 1'b1; message_addr = 16'h2000;
    load_msg(13, 16'h2000);
    push_msg(13, 16'h2000);
    pulse_start();
    wait_valid(40, ok, cyc);
    tests_run++;
    if (!ok || cyc != 17) begin tests_failed++; $display("FAIL n13_latency got %0d edges ok=%b required 17", cyc, ok); end
    pop_exp();
    tests_run++;
    if (v_data !== e.data) begin tests_failed++; $display("FAIL n13_data got %h required %h", v_data, e.data); end
    tests_run++;
    if (v_data[95:0] !== {32'h8000_0000, 32'h0, 32'h0000_01A0}) begin
      tests_failed++; $display("FAIL n13_pad got %h required 80000000_00000000_000001a0", v_data[95:0]);
    end
    tests_run++;
    if ({v_last, v_idx} !== {1'b1, 8'd0}) begin tests_failed++; $display("FAIL n13_last got last=%b idx=%0d required 1 0", v_last, v_idx); end
    @(negedge clk);
    tests_run++;
    if (v_done !== 1'b1) begin tests_failed++; $display("FAIL n13_done got %b required 1", v_done); end
    @(negedge clk);
  endtask

  task automatic test_n14();
    bit ok; int cyc;
    sel = 2'd2; ready = 1'b1; message_addr = 16'h1000;
    load_msg(14, 16'h1000);
    push_msg(14, 16'h1000);
    pulse_start();
    for (int b = 0; b < 2; b++) begin
      wait_valid(40, ok, cyc);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL n14_timeout blk%0d got no valid in %0d edges required valid", b, cyc); end
      pop_exp();
      tests_run++;
      if ({v_data, v_last, v_idx} !== {e.data, e.last, e.idx}) begin
        tests_failed++; $display("FAIL n14_blk%0d got %h last=%b idx=%0d required %h last=%b idx=%0d", b, v_data, v_last, v_idx, e.data, e.last, e.idx);
      end
      tests_run++;
      if (b == 0 && {v_data[63:0], v_last} !== {32'h8000_0000, 32'h0, 1'b0}) begin
        tests_failed++; $display("FAIL n14_blk0_pad got %h last=%b required 8000000000000000 last=0", v_data[63:0], v_last);
      end else if (b == 1 && {v_data, v_last} !== {480'd0, 32'h0000_01C0, 1'b1}) begin
        tests_failed++; $display("FAIL n14_blk1_len got %h last=%b required zeros with 000001c0 last=1", v_data, v_last);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; int cyc;
    logic [511:0] d0;
    logic [15:0]  a0;
    sel = 2'd0; ready = 1'b0; message_addr = 16'h0300;
    load_msg(20, 16'h0300);
    push_msg(20, 16'h0300);
    pulse_start();
    wait_valid(40, ok, cyc);
    tests_run++;
    if (!ok || cyc != 17) begin tests_failed++; $display("FAIL bp_latency got %0d edges ok=%b required 17", cyc, ok); end
    d0 = v_data; a0 = v_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({v_valid, v_data, v_addr} !== {1'b1, d0, a0}) begin
        tests_failed++; $display("FAIL bp_hold cycle%0d got valid=%b addr=%h required valid=1 addr=%h data held", i, v_valid, v_addr, a0);
      end
    end
    pop_exp();
    tests_run++;
    if (d0 !== e.data) begin tests_failed++; $display("FAIL bp_blk0 got %h required %h", d0, e.data); end
    ready = 1'b1;
    wait_valid(40, ok, cyc);
    tests_run++;
    if (!ok || cyc != 18) begin tests_failed++; $display("FAIL bp_next_latency got %0d edges ok=%b required 18", cyc, ok); end
    pop_exp();
    tests_run++;
    if ({v_data, v_last, v_idx} !== {e.data, e.last, e.idx}) begin
      tests_failed++; $display("FAIL bp_blk1 got %h last=%b idx=%0d required %h last=%b idx=%0d", v_data, v_last, v_idx, e.data, e.last, e.idx);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midfill();
    bit ok; int cyc;
    bit saw;
    sel = 2'd0; ready = 1'b1; message_addr = 16'h0400;
    load_msg(20, 16'h0400);
    push_msg(20, 16'h0400);
    pulse_start();
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({v_valid, v_last, v_idx, v_busy, v_done, v_addr, v_we} !== 29'd0 || v_data !== 512'd0) begin
      tests_failed++; $display("FAIL midfill_reset got valid=%b last=%b idx=%0d busy=%b done=%b addr=%h we=%b data=%h required all 0",
                               v_valid, v_last, v_idx, v_busy, v_done, v_addr, v_we, v_data);
    end
    reset = 1'b0;
    sb.delete();
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (v_done || v_valid || v_busy) saw = 1'b1;
    end
    tests_run++;
    if (saw !== 1'b0) begin tests_failed++; $display("FAIL midfill_quiet got activity=%b required 0", saw); end
    for (int i = 0; i < 20; i++) mem[16'h0400 + 16'(i)] = 32'hA500_0000 + 32'(i);
    push_msg(20, 16'h0400);
    pulse_start();
    for (int b = 0; b < 2; b++) begin
      wait_valid(40, ok, cyc);
      pop_exp();
      tests_run++;
      if (!ok || {v_data, v_last, v_idx} !== {e.data, e.last, e.idx}) begin
        tests_failed++; $display("FAIL midfill_restart blk%0d ok=%b got %h last=%b idx=%0d required %h", b, ok, v_data, v_last, v_idx, e.data);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bswap();
    bit ok; int cyc;
    logic [31:0] w0;
`ifdef SHA256_PADDER_BSWAP_EN
    w0 = 32'h4433_2211;
`else
    w0 = 32'h1122_3344;
`endif
    sel = 2'd1; ready = 1'b1; message_addr = 16'h3000;
    load_msg(13, 16'h3000);
    mem[16'h3000] = 32'h1122_3344;
    push_msg(13, 16'h3000);
    pulse_start();
    wait_valid(40, ok, cyc);
    pop_exp();
    tests_run++;
    if (!ok || v_data !== e.data) begin tests_failed++; $display("FAIL bswap_data ok=%b got %h required %h", ok, v_data, e.data); end
    tests_run++;
    if ({v_data[511:480], v_data[95:64], v_data[31:0]} !== {w0, 32'h8000_0000, 32'h0000_01A0}) begin
      tests_failed++; $display("FAIL bswap_words got w0=%h w13=%h w15=%h required %h 80000000 000001a0",
                               v_data[511:480], v_data[95:64], v_data[31:0], w0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc;
    sel = 2'd1; ready = 1'b1; message_addr = 16'h5000;
    load_msg(13, 16'h5000);
    push_msg(13, 16'h5000);
    push_msg(13, 16'h5000);
    start = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      wait_valid(40, ok, cyc);
      tests_run++;
      if (!ok || cyc != 17) begin tests_failed++; $display("FAIL b2b_latency msg%0d got %0d edges ok=%b required 17", m, cyc, ok); end
      pop_exp();
      tests_run++;
      if ({v_data, v_last, v_idx} !== {e.data, e.last, e.idx}) begin
        tests_failed++; $display("FAIL b2b_data msg%0d got %h last=%b idx=%0d required %h", m, v_data, v_last, v_idx, e.data);
      end
      @(negedge clk);
      tests_run++;
      if (v_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done msg%0d got %b required 1", m, v_done); end
      if (m == 0) begin
        @(negedge clk);
        tests_run++;
        if (v_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got busy=%b required 0", v_busy); end
        @(negedge clk);
        tests_run++;
        if (v_busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_relaunch got busy=%b required 1", v_busy); end
        start = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || v_busy !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain got %0d queued busy=%b required 0 0", sb.size(), v_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    test_reset();
    test_n20(16'h0100);
    test_n20(16'hFFF8);
    test_n13();
    test_n14();
    test_backpressure();
    test_reset_midfill();
    test_bswap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion required finish before 500000 ns");
    $fatal(1);
  end

endmodule
